// File: rtl/axis_frame_tx_f32.sv
// axis_frame_tx_f32
// Buffers float32 samples from an upstream valid/ready port in a small FIFO
// and replays them as AXI-Stream beats, marking every FRAME_LEN-th beat with
// tlast. The head of the FIFO is held in an output register so that every
// AXI-Stream output comes straight from a flop. Data is passed bit-exact.
module axis_frame_tx_f32 #(
  parameter int FRAME_LEN = 4,
  parameter int FIFO_AW   = 3,
  parameter int CNT_W     = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             frame_done,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  // storage and state
  logic [31:0]      mem_r [DEPTH];
  logic [FIFO_AW:0] wr_ptr_r;
  logic [FIFO_AW:0] rd_ptr_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [CNT_W-1:0] frames_sent_r;
  logic             in_ready_r;
  logic             tvalid_r;
  logic [31:0]      tdata_r;
  logic             tlast_r;
  logic             frame_done_r;

  // next-state values
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [FIFO_AW:0] wr_ptr_nxt_s;
  logic [FIFO_AW:0] rd_ptr_nxt_s;
  logic [FIFO_AW:0] rd_ptr_inc_s;
  logic             full_nxt_s;
  logic             empty_nxt_s;
  logic [31:0]      head_nxt_s;
  logic [CNT_W-1:0] beat_cnt_nxt_s;
  logic [CNT_W-1:0] frames_sent_nxt_s;
  logic             tlast_nxt_s;
  logic             frame_done_nxt_s;

  // Handshakes, pointer updates, next head word and framing counters.
  always_comb begin
    full_s  = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
              (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    empty_s = (wr_ptr_r == rd_ptr_r);
    push_s  = in_valid & in_ready_r & ~full_s;
    pop_s   = tvalid_r & m_axis_tready & ~empty_s;
    rd_ptr_inc_s = rd_ptr_r + PTR_ONE;

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_inc_s;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    full_nxt_s  = (wr_ptr_nxt_s[FIFO_AW] != rd_ptr_nxt_s[FIFO_AW]) &&
                  (wr_ptr_nxt_s[FIFO_AW-1:0] == rd_ptr_nxt_s[FIFO_AW-1:0]);
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);

    // After a pop the new head is the stored entry behind it, or the word
    // being pushed right now when the FIFO held only one entry.
    if (pop_s) begin
      if (rd_ptr_inc_s != wr_ptr_r) begin
        head_nxt_s = mem_r[rd_ptr_inc_s[FIFO_AW-1:0]];
      end else if (push_s) begin
        head_nxt_s = in_data;
      end else begin
        head_nxt_s = tdata_r;
      end
    end else if (empty_s && push_s) begin
      head_nxt_s = in_data;
    end else begin
      head_nxt_s = tdata_r;
    end

    if (pop_s) begin
      if (tlast_r) begin
        beat_cnt_nxt_s    = CNT_ZERO;
        frames_sent_nxt_s = frames_sent_r + CNT_ONE;
      end else begin
        beat_cnt_nxt_s    = beat_cnt_r + CNT_ONE;
        frames_sent_nxt_s = frames_sent_r;
      end
    end else begin
      beat_cnt_nxt_s    = beat_cnt_r;
      frames_sent_nxt_s = frames_sent_r;
    end

    frame_done_nxt_s = pop_s & tlast_r;
    tlast_nxt_s      = ~empty_nxt_s & (beat_cnt_nxt_s == LAST_BEAT);
  end

  // FIFO storage write; contents need no reset because pointers gate them.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[FIFO_AW-1:0]] <= in_data;
    end
  end

  // Pointer, counter and registered output state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r      <= {(FIFO_AW+1){1'b0}};
      rd_ptr_r      <= {(FIFO_AW+1){1'b0}};
      beat_cnt_r    <= CNT_ZERO;
      frames_sent_r <= CNT_ZERO;
      in_ready_r    <= 1'b0;
      tvalid_r      <= 1'b0;
      tdata_r       <= 32'h0000_0000;
      tlast_r       <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      wr_ptr_r      <= wr_ptr_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      beat_cnt_r    <= beat_cnt_nxt_s;
      frames_sent_r <= frames_sent_nxt_s;
      in_ready_r    <= ~full_nxt_s;
      tvalid_r      <= ~empty_nxt_s;
      tdata_r       <= head_nxt_s;
      tlast_r       <= tlast_nxt_s;
      frame_done_r  <= frame_done_nxt_s;
    end
  end

  assign in_ready      = in_ready_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tdata  = tdata_r;
  assign m_axis_tlast  = tlast_r;
  assign frame_done    = frame_done_r;
  assign frames_sent   = frames_sent_r;

endmodule

// File: tb/tb_axis_frame_tx_f32.sv
// Testbench for axis_frame_tx_f32: a table of cycle vectors for the basic
// frame, a queue-based reference model for directed and random traffic,
// and a second instance built with FRAME_LEN=1.
module tb_axis_frame_tx_f32;

  localparam int FL    = 4;
  localparam int DEPTH = 8;

  logic        clk;
  logic        aresetn;
  logic        in_valid, in_ready, m_tvalid, m_tready, m_tlast, frame_done;
  logic [31:0] in_data, m_tdata;
  logic [15:0] frames_sent;
  logic        in_valid_1, in_ready_1, m_tvalid_1, m_tready_1, m_tlast_1, frame_done_1;
  logic [31:0] in_data_1, m_tdata_1;
  logic [15:0] frames_sent_1;

  int total = 0;
  int bad   = 0;

  axis_frame_tx_f32 #(.FRAME_LEN(FL), .FIFO_AW(3), .CNT_W(16)) dut (
    .aclk(clk), .aresetn(aresetn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .frame_done(frame_done), .frames_sent(frames_sent)
  );

  axis_frame_tx_f32 #(.FRAME_LEN(1), .FIFO_AW(3), .CNT_W(16)) dut1 (
    .aclk(clk), .aresetn(aresetn),
    .in_valid(in_valid_1), .in_data(in_data_1), .in_ready(in_ready_1),
    .m_axis_tvalid(m_tvalid_1), .m_axis_tready(m_tready_1),
    .m_axis_tdata(m_tdata_1), .m_axis_tlast(m_tlast_1),
    .frame_done(frame_done_1), .frames_sent(frames_sent_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        tr;
    logic        e_tv;
    logic [31:0] e_td;
    logic        e_tl;
    logic        e_rdy;
    logic        e_fd;
    logic [15:0] e_fs;
  } vec_t;

  vec_t vec  [7];
  vec_t vec1 [5];

  // reference model state
  logic [31:0] q[$];
  int unsigned beats;
  int unsigned frames;
  bit          fd_exp;
  bit          rdy_en;
  bit          last_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    beats  = 0;
    frames = 0;
    fd_exp = 1'b0;
    rdy_en = 1'b0;
  endtask

  task automatic model_check();
    bit tv;
    tv = (q.size() > 0);
    chk("tvalid", {31'd0, m_tvalid}, {31'd0, tv});
    if (tv) chk("tdata", m_tdata, q[0]);
    chk("tlast", {31'd0, m_tlast}, {31'd0, tv && (beats % FL == FL - 1)});
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_en && (q.size() < DEPTH)});
    chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
    chk("frames_sent", {16'd0, frames_sent}, frames % 65536);
  endtask

  // one clock of the main DUT with the model stepped alongside it
  task automatic cycle();
    bit push, pop, tl;
    logic [31:0] d;
    push = in_valid && rdy_en && (q.size() < DEPTH);
    pop  = (q.size() > 0) && m_tready;
    tl   = pop && (beats % FL == FL - 1);
    d    = in_data;
    @(posedge clk);
    fd_exp = tl;
    if (pop) begin
      q.delete(0);
      beats++;
      if (tl) frames++;
    end
    if (push) q.push_back(d);
    rdy_en    = 1'b1;
    last_push = push;
    @(negedge clk);
    model_check();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    aresetn  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int k;
    int n;
    vec[0] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'd0};
    vec[1] = '{1'b1, 32'h3E9E377A, 1'b1, 1'b1, 32'h3E9E377A, 1'b0, 1'b1, 1'b0, 16'd0};
    vec[2] = '{1'b1, 32'h3E9E377A, 1'b1, 1'b1, 32'h3E9E377A, 1'b0, 1'b1, 1'b0, 16'd0};
    vec[3] = '{1'b1, 32'h3E9E377A, 1'b1, 1'b1, 32'h3E9E377A, 1'b0, 1'b1, 1'b0, 16'd0};
    vec[4] = '{1'b1, 32'h3E9E377A, 1'b1, 1'b1, 32'h3E9E377A, 1'b1, 1'b1, 1'b0, 16'd0};
    vec[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 16'd1};
    vec[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'd1};

    vec1[0] = '{1'b1, 32'h11, 1'b1, 1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 16'd0};
    vec1[1] = '{1'b1, 32'h22, 1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 16'd1};
    vec1[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 16'd2};
    vec1[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 16'd3};
    vec1[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 16'd3};

    aresetn    = 1'b0;
    in_valid   = 1'b0; in_data   = 32'h0; m_tready   = 1'b1;
    in_valid_1 = 1'b0; in_data_1 = 32'h0; m_tready_1 = 1'b1;
    model_reset();

    // reset state
    #12;
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frames_sent", {16'd0, frames_sent}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    #1 chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);

    // basic frame from the vector table
    for (int i = 0; i < 7; i++) begin
      in_valid = vec[i].iv; in_data = vec[i].id; m_tready = vec[i].tr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_tvalid", i), {31'd0, m_tvalid}, {31'd0, vec[i].e_tv});
      if (vec[i].e_tv) chk($sformatf("vec%0d_tdata", i), m_tdata, vec[i].e_td);
      chk($sformatf("vec%0d_tlast", i), {31'd0, m_tlast}, {31'd0, vec[i].e_tl});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vec[i].e_rdy});
      chk($sformatf("vec%0d_frame_done", i), {31'd0, frame_done}, {31'd0, vec[i].e_fd});
      chk($sformatf("vec%0d_frames_sent", i), {16'd0, frames_sent}, {16'd0, vec[i].e_fs});
    end

    // two samples, idle gap, two samples
    apply_reset();
    in_valid = 1'b0; m_tready = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 2) || (i >= 8);
      in_data  = 32'h4000_0000 + i;
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("gap_frames_sent", {16'd0, frames_sent}, 32'd1);

    // backpressure while pushing ten samples
    m_tready = 1'b0;
    k = 1;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; in_data = k;
      cycle();
      if (last_push) k++;
    end
    chk("accepted_while_stalled", k - 1, 32'd8);
    m_tready = 1'b1;
    n = 0;
    while ((k <= 10 || q.size() > 0) && n < 60) begin
      in_valid = (k <= 10); in_data = k;
      cycle();
      if (last_push) k++;
      n++;
    end
    chk("all_ten_sent", k - 1, 32'd10);
    chk("drain_in_time", {31'd0, (n < 60)}, 32'd1);

    // full FIFO, continuous push, ready toggling every cycle
    in_valid = 1'b1; m_tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_data = $urandom;
      cycle();
    end
    for (int c = 0; c < 40; c++) begin
      in_data  = $urandom;
      m_tready = c[0];
      cycle();
    end
    in_valid = 1'b0; m_tready = 1'b1;
    repeat (10) cycle();

    // asynchronous reset after beat 2 of a frame
    in_valid = 1'b1; m_tready = 1'b1;
    n = 0;
    while ((beats % FL != 2 || q.size() == 0) && n < 20) begin
      in_data = $urandom;
      cycle();
      n++;
    end
    chk("reached_beat2", {31'd0, (n < 20)}, 32'd1);
    in_valid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("async_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("async_tdata", m_tdata, 32'd0);
    chk("async_tlast", {31'd0, m_tlast}, 32'd0);
    chk("async_frame_done", {31'd0, frame_done}, 32'd0);
    chk("async_frames_sent", {16'd0, frames_sent}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd0);
    model_reset();
    #1 aresetn = 1'b1;
    cycle();
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = 32'h5000_0000 + c;
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    chk("post_reset_frames", {16'd0, frames_sent}, 32'd2);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      m_tready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid = 1'b0; m_tready = 1'b1;
    repeat (10) cycle();

    // FRAME_LEN=1 instance: tlast and frame_done on every beat
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_valid_1 = vec1[i].iv; in_data_1 = vec1[i].id; m_tready_1 = vec1[i].tr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("fl1_%0d_tvalid", i), {31'd0, m_tvalid_1}, {31'd0, vec1[i].e_tv});
      if (vec1[i].e_tv) chk($sformatf("fl1_%0d_tdata", i), m_tdata_1, vec1[i].e_td);
      chk($sformatf("fl1_%0d_tlast", i), {31'd0, m_tlast_1}, {31'd0, vec1[i].e_tl});
      chk($sformatf("fl1_%0d_in_ready", i), {31'd0, in_ready_1}, {31'd0, vec1[i].e_rdy});
      chk($sformatf("fl1_%0d_frame_done", i), {31'd0, frame_done_1}, {31'd0, vec1[i].e_fd});
      chk($sformatf("fl1_%0d_frames_sent", i), {16'd0, frames_sent_1}, {16'd0, vec1[i].e_fs});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
